// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] NULL_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Circular fetch queue holding {pc, instr} pairs; flush dominates push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH-1:0] push_pc_i,
    input  logic [INST_WIDTH-1:0] push_instr_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] head_pc_o,
    output logic [INST_WIDTH-1:0] head_instr_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [PW:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [INST_WIDTH-1:0] instr_mem_q [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    // A push into a full queue is only legal when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != FULL_CNT) || do_pop);
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                tail_d = tail_q + PW'(1);
            end
            if (do_pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            pc_mem_q[tail_q]    <= push_pc_i;
            instr_mem_q[tail_q] <= push_instr_i;
        end
    end

    always_comb begin
        full_o       = (count_q == FULL_CNT);
        valid_o      = (count_q != '0);
        head_pc_o    = valid_o ? pc_mem_q[head_q]    : '0;
        head_instr_o = valid_o ? instr_mem_q[head_q] : '0;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register, fetch FSM and redirect handling in front of a fetch queue to decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects halt fetch and set sticky misalign_err.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            FQ_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  halted
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_err
`endif
);

    // Decode handshake: a head entry transfers on any rising edge where inst_valid and
    // inst_ready are both high; inst_valid never depends on inst_ready.

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  pop;
    logic                  q_full;
    logic                  fetch_en;
    logic                  is_null;
    logic                  push;
    logic                  redirect_take;
    logic                  target_bad;

    assign imem_addr   = {2'b00, pc_q[ADDR_WIDTH-1:2]};
    assign redirect_pc = redirect_target & ~ADDR_WIDTH'(2'b11);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_err_q;

    assign target_bad = (redirect_target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err_q <= 1'b0;
        end else if (redirect_take && target_bad) begin
            misalign_err_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_err_q;
`else
    assign target_bad = 1'b0;
`endif

    // Redirect wins over fetch; a null word ends the fetch stream without being queued.
    always_comb begin
        pop           = inst_valid && inst_ready;
        redirect_take = redirect_valid && (state_q != BOOT);
        is_null       = (imem_instr == INST_WIDTH'(NULL_INSTR));
        fetch_en      = (state_q == RUN) && !redirect_valid && (!q_full || pop);
        push          = fetch_en && !is_null;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_take) begin
                    state_d = target_bad ? HALT : RUN;
                end else if (fetch_en && is_null) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (redirect_take) begin
                    state_d = target_bad ? HALT : RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        if (redirect_take) begin
            if (!target_bad) begin
                pc_d = redirect_pc;
            end
        end else if (push) begin
            pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
        end
    end

    always_comb begin
        halted = (state_q == HALT);
    end

    fetch_queue #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .DEPTH      (FQ_DEPTH)
    ) u_fetch_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_pc_i    (pc_q),
        .push_instr_i (imem_instr),
        .pop_i        (pop),
        .flush_i      (redirect_take),
        .full_o       (q_full),
        .valid_o      (inst_valid),
        .head_pc_o    (inst_pc),
        .head_instr_o (inst_out)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Table-driven bench for instr_fetch_unit: cycle vectors plus async-reset and PC-wrap sequences.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] WRAP_WORD = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        rv;
    logic [31:0] tgt;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_halted;
    logic [31:0] e_addr;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  logic [63:0] exp_q[$];

  instr_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .halted          (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_err    (misalign_err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // instruction memory model (word indexed, combinational)
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'd0:          return 32'h0041_82b3;
      32'd1:          return 32'h4041_8333;
      32'd2:          return 32'h0041_93b3;
      32'd3:          return 32'h0000_0000;
      32'd4:          return 32'h00a0_0093;
      32'd5:          return 32'h00b0_0113;
      32'd6:          return 32'h00c0_0193;
      32'd7:          return 32'h0000_0000;
      32'h3FFF_FFFF:  return WRAP_WORD;
      default:        return 32'h0000_0000;
    endcase
  endfunction

  always_comb imem_instr = mem_read(imem_addr);

  // driver / checker helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic rdy, input logic rv, input logic [31:0] tgt,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                              input logic eh, input logic [31:0] ea, input logic em);
    vec_t v;
    v.rst = r; v.ready = rdy; v.rv = rv; v.tgt = tgt;
    v.e_valid = ev; v.e_pc = epc; v.e_instr = ein; v.e_halted = eh; v.e_addr = ea; v.e_mis = em;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] tgt);
    rst             = r;
    inst_ready      = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
  endtask

  initial begin
    int edges;
    int cyc;
    logic [63:0] got;
    logic [63:0] exp;

    drive(1'b1, 1'b0, 1'b0, 32'h0);

    // Each row: outputs expected at this negedge, then inputs held for the next rising edge.
    //   rst rdy rv tgt           valid pc     instr          halt addr   mis
    add(0, 1, 0, 32'h0,         0, 32'h0,  32'h0,          0, 32'd0, 0); // r0  BOOT
    add(0, 1, 0, 32'h0,         0, 32'h0,  32'h0,          0, 32'd0, 0); // r1  RUN, first fetch at next edge
    add(0, 1, 0, 32'h0,         1, 32'h0,  32'h0041_82b3,  0, 32'd1, 0);
    add(0, 1, 0, 32'h0,         1, 32'h4,  32'h4041_8333,  0, 32'd2, 0);
    add(0, 1, 0, 32'h0,         1, 32'h8,  32'h0041_93b3,  0, 32'd3, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,  32'h0,          1, 32'd3, 0); // r5  halted on null word
    add(0, 1, 1, 32'h4,         0, 32'h0,  32'h0,          1, 32'd3, 0); // r6  redirect out of HALT
    add(0, 1, 0, 32'h0,         0, 32'h0,  32'h0,          0, 32'd1, 0);
    add(0, 1, 0, 32'h0,         1, 32'h4,  32'h4041_8333,  0, 32'd2, 0);
    add(0, 1, 0, 32'h0,         1, 32'h8,  32'h0041_93b3,  0, 32'd3, 0);
    add(1, 0, 0, 32'h0,         0, 32'h0,  32'h0,          1, 32'd3, 0); // r10 reset
    add(0, 0, 1, 32'h10,        0, 32'h0,  32'h0,          0, 32'd0, 0); // r11 redirect in BOOT ignored
    add(0, 0, 0, 32'h0,         0, 32'h0,  32'h0,          0, 32'd0, 0);
    add(0, 0, 0, 32'h0,         1, 32'h0,  32'h0041_82b3,  0, 32'd1, 0);
    add(0, 0, 0, 32'h0,         1, 32'h0,  32'h0041_82b3,  0, 32'd2, 0); // r14 full, pc holds 8
    add(0, 0, 0, 32'h0,         1, 32'h0,  32'h0041_82b3,  0, 32'd2, 0);
    add(0, 1, 0, 32'h0,         1, 32'h0,  32'h0041_82b3,  0, 32'd2, 0); // r16 push+pop while full
    add(0, 1, 0, 32'h0,         1, 32'h4,  32'h4041_8333,  0, 32'd3, 0);
    add(0, 1, 0, 32'h0,         1, 32'h8,  32'h0041_93b3,  1, 32'd3, 0);
    add(0, 0, 1, 32'h0,         0, 32'h0,  32'h0,          1, 32'd3, 0); // r19 restart at 0
    add(0, 0, 0, 32'h0,         0, 32'h0,  32'h0,          0, 32'd0, 0);
    add(0, 0, 0, 32'h0,         1, 32'h0,  32'h0041_82b3,  0, 32'd1, 0);
    add(0, 1, 1, 32'h10,        1, 32'h0,  32'h0041_82b3,  0, 32'd2, 0); // r22 redirect with full queue
    add(0, 1, 0, 32'h0,         0, 32'h0,  32'h0,          0, 32'd4, 0);
    add(0, 1, 0, 32'h0,         1, 32'h10, 32'h00a0_0093,  0, 32'd5, 0);
    add(0, 1, 0, 32'h0,         1, 32'h14, 32'h00b0_0113,  0, 32'd6, 0);
    add(0, 1, 0, 32'h0,         1, 32'h18, 32'h00c0_0193,  0, 32'd7, 0);
    add(0, 1, 1, 32'h6,         0, 32'h0,  32'h0,          1, 32'd7, 0); // r27 misaligned redirect
`ifdef FETCH_MISALIGN_TRAP_EN
    add(0, 1, 0, 32'h0,         0, 32'h0,  32'h0,          1, 32'd7, 1);
    add(0, 0, 0, 32'h0,         0, 32'h0,  32'h0,          1, 32'd7, 1);
`else
    add(0, 1, 0, 32'h0,         0, 32'h0,  32'h0,          0, 32'd1, 0);
    add(0, 0, 0, 32'h0,         1, 32'h4,  32'h4041_8333,  0, 32'd2, 0);
`endif

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid",  64'(inst_valid), 64'(1'b0));
    check("reset_pc",     64'(inst_pc),    64'(32'h0));
    check("reset_instr",  64'(inst_out),   64'(32'h0));
    check("reset_halted", 64'(halted),     64'(1'b0));
    check("reset_addr",   64'(imem_addr),  64'(32'h0));
`ifdef FETCH_MISALIGN_TRAP_EN
    check("reset_misalign", 64'(misalign_err), 64'(1'b0));
`endif

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      check($sformatf("r%0d_valid", i),  64'(inst_valid), 64'(vecs[i].e_valid));
      check($sformatf("r%0d_pc", i),     64'(inst_pc),    64'(vecs[i].e_pc));
      check($sformatf("r%0d_instr", i),  64'(inst_out),   64'(vecs[i].e_instr));
      check($sformatf("r%0d_halted", i), 64'(halted),     64'(vecs[i].e_halted));
      check($sformatf("r%0d_addr", i),   64'(imem_addr),  64'(vecs[i].e_addr));
`ifdef FETCH_MISALIGN_TRAP_EN
      check($sformatf("r%0d_misalign", i), 64'(misalign_err), 64'(vecs[i].e_mis));
`endif
      drive(vecs[i].rst, vecs[i].ready, vecs[i].rv, vecs[i].tgt);
    end

    // async reset pulsed between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid",  64'(inst_valid), 64'(1'b0));
    check("async_rst_pc",     64'(inst_pc),    64'(32'h0));
    check("async_rst_instr",  64'(inst_out),   64'(32'h0));
    check("async_rst_halted", 64'(halted),     64'(1'b0));
    check("async_rst_addr",   64'(imem_addr),  64'(32'h0));
`ifdef FETCH_MISALIGN_TRAP_EN
    check("async_rst_misalign", 64'(misalign_err), 64'(1'b0));
`endif
    #1 rst = 1'b0;
    edges = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      edges++;
      #1;
      if (inst_valid) break;
    end
    check("restart_latency_edges", 64'(edges), 64'(2));
    check("restart_pc",    64'(inst_pc),  64'(32'h0));
    check("restart_instr", 64'(inst_out), 64'(32'h0041_82b3));

    // redirect to the top word, PC wraps to 0 after it
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_addr",  64'(imem_addr),  64'(32'h3FFF_FFFF));
    check("wrap_flush", 64'(inst_valid), 64'(1'b0));
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    exp_q.push_back({32'hFFFF_FFFC, WRAP_WORD});
    exp_q.push_back({32'h0000_0000, 32'h0041_82b3});
    exp_q.push_back({32'h0000_0004, 32'h4041_8333});
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (inst_valid) begin
        got = {inst_pc, inst_out};
        exp = exp_q.pop_front();
        check("wrap_handshake", got, exp);
      end
    end
    check("wrap_sb_drained", 64'(exp_q.size()), 64'(0));

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
